// File: rtl/rom_burst_reader_pkg.sv
// Shared types and default widths for the ROM burst reader.
package rom_burst_reader_pkg;

    localparam int unsigned RBR_ADDR_W = 4;
    localparam int unsigned RBR_DATA_W = 16;
    localparam int unsigned RBR_LEN_W  = RBR_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } rbr_state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// Walks a burst of consecutive ROM addresses and streams each word over valid/ready,
// keeping a running checksum and pulsing done once the final word is accepted.
module rom_burst_reader
    import rom_burst_reader_pkg::*;
#(
    parameter int unsigned ADDR_W = RBR_ADDR_W,
    parameter int unsigned DATA_W = RBR_DATA_W,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    rbr_state_t        state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d, sum_d;
    logic              valid_d, last_d, busy_d, done_d;
    logic              fetch_c;

    // Next-state and next-value logic for every register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = rom_addr;
        data_d  = out_data;
        valid_d = out_valid;
        last_d  = out_last;
        sum_d   = checksum;
        fetch_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sum_d = '0;
                    if (burst_len != '0) begin
                        addr_d  = start_addr;
                        cnt_d   = burst_len;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                fetch_c = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        fetch_c = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A fetch captures the current ROM word and advances to the next address.
        if (fetch_c) begin
            data_d  = rom_data;
            valid_d = 1'b1;
            last_d  = (cnt_q == LEN_W'(1));
            sum_d   = checksum + rom_data;
            addr_d  = rom_addr + ADDR_W'(1);
            cnt_d   = cnt_q - LEN_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rom_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rom_addr  <= addr_d;
            out_data  <= data_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            checksum  <= sum_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
